alu_share_arb: RTL

Two-port arbiter that time-shares the single RV32 ALU between the pipeline EX stage (port 0) and a secondary requester such as a branch-target or iterative multiply/divide unit (port 1). It selects one request per cycle and drives the external ALU instance combinationally. It captures the result and flags into a one-entry response register with valid/ready backpressure. Port 0 has fixed priority, with optional starvation protection for port 1.

---
 rtl/alu_pkg.sv | 37 +++
 rtl/alu_arb_grant.sv | 67 ++++++
 rtl/alu_share_arb.sv | 130 +++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sharing arbiter: ALU function codes,
// flag bit positions, port identifiers and the starvation counter width.
package alu_pkg;

    // ALU function codes (shift family is 4'b10xx, low bits pick the shift type)
    localparam logic [3:0] ALUFN_ADD   = 4'b0000;
    localparam logic [3:0] ALUFN_SUB   = 4'b0001;
    localparam logic [3:0] ALUFN_PASSB = 4'b0011;
    localparam logic [3:0] ALUFN_OR    = 4'b0100;
    localparam logic [3:0] ALUFN_AND   = 4'b0101;
    localparam logic [3:0] ALUFN_XOR   = 4'b0111;
    localparam logic [3:0] ALUFN_SLL   = 4'b1000;
    localparam logic [3:0] ALUFN_SRL   = 4'b1001;
    localparam logic [3:0] ALUFN_SRA   = 4'b1011;
    localparam logic [3:0] ALUFN_SLT   = 4'b1101;
    localparam logic [3:0] ALUFN_SLTU  = 4'b1111;

    // Bit positions inside the packed {cf,zf,vf,sf} flag vector
    localparam int FLAG_CF = 3;
    localparam int FLAG_ZF = 2;
    localparam int FLAG_VF = 1;
    localparam int FLAG_SF = 0;

    // Requester identifiers
    localparam logic PORT_EX  = 1'b0;
    localparam logic PORT_AUX = 1'b1;

    // Width of the starvation counter (limit range 1..15)
    localparam int STARVE_CNT_W = 4;

    // Pack the individual ALU flags into the response flag vector
    function automatic logic [3:0] pack_flags(input logic cf, input logic zf,
                                              input logic vf, input logic sf);
        return {cf, zf, vf, sf};
    endfunction

endpackage

// File: rtl/alu_arb_grant.sv
// Grant selection for the shared ALU. Port 0 (EX) has fixed priority.
// With ALU_ARB_STARVE_EN defined, a saturating counter of port-0 wins taken
// while port 1 waits forces one port-1 grant once it reaches STARVE_LIMIT.
module alu_arb_grant
    import alu_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
`ifdef ALU_ARB_STARVE_EN
    input  logic clk,
    input  logic rst_n,
    input  logic slot_free,
`endif
    input  logic req0_valid,
    input  logic req1_valid,
    output logic gnt_vld,
    output logic gnt_id
);

`ifdef ALU_ARB_STARVE_EN
    localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

    logic [STARVE_CNT_W-1:0] starve_cnt_q;
    logic [STARVE_CNT_W-1:0] starve_cnt_d;
    logic                    force_aux;
    logic                    fire;

    assign force_aux = (starve_cnt_q == LIMIT) && req1_valid;
    assign fire      = gnt_vld && slot_free;

    // Priority select, overridden toward port 1 once it has waited long enough
    always_comb begin
        gnt_vld = req0_valid || req1_valid;
        gnt_id  = (force_aux || !req0_valid) ? PORT_AUX : PORT_EX;
    end

    // Count port-0 wins while port 1 waits; clear when port 1 is served or leaves
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!req1_valid) begin
            starve_cnt_d = '0;
        end else if (fire) begin
            if (gnt_id == PORT_AUX) begin
                starve_cnt_d = '0;
            end else if (starve_cnt_q != LIMIT) begin
                starve_cnt_d = starve_cnt_q + 1'b1;
            end
        end
    end

    // Starvation counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`else
    // Strict fixed priority: port 1 only when port 0 is idle
    always_comb begin
        gnt_vld = req0_valid || req1_valid;
        gnt_id  = req0_valid ? PORT_EX : PORT_AUX;
    end
`endif

endmodule

// File: rtl/alu_share_arb.sv
// Two-port arbiter sharing one external RV32 ALU between the EX stage
// (port 0) and an auxiliary requester (port 1). The granted request drives
// the ALU combinationally; the result is captured in a one-entry response
// register with valid/ready handshake. Optional starvation protection for
// port 1 is enabled with the ALU_ARB_STARVE_EN macro.
module alu_share_arb
    import alu_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [4:0]  req0_shamt,
    input  logic [3:0]  req0_alufn,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [4:0]  req1_shamt,
    input  logic [3:0]  req1_alufn,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [4:0]  alu_shamt,
    output logic [3:0]  alu_alufn,
    input  logic [31:0] alu_r,
    input  logic        alu_cf,
    input  logic        alu_zf,
    input  logic        alu_vf,
    input  logic        alu_sf,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_r,
    output logic [3:0]  rsp_flags
);

    logic        gnt_vld;
    logic        gnt_id;
    logic        gnt_live;
    logic        slot_free;
    logic        fire;

    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_id_q,    rsp_id_d;
    logic [31:0] rsp_r_q,     rsp_r_d;
    logic [3:0]  rsp_flags_q, rsp_flags_d;

    alu_arb_grant #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_grant (
`ifdef ALU_ARB_STARVE_EN
        .clk        (clk),
        .rst_n      (rst_n),
        .slot_free  (slot_free),
`endif
        .req0_valid (req0_valid),
        .req1_valid (req1_valid),
        .gnt_vld    (gnt_vld),
        .gnt_id     (gnt_id)
    );

    // Grant is suppressed while reset is asserted so readies and ALU drive read 0
    assign gnt_live   = gnt_vld && rst_n;
    assign slot_free  = !rsp_valid_q || rsp_ready;
    assign fire       = gnt_live && slot_free;
    assign req0_ready = fire && (gnt_id == PORT_EX);
    assign req1_ready = fire && (gnt_id == PORT_AUX);

    // Operand mux toward the ALU; follows the grant even when the slot is busy
    always_comb begin
        alu_a     = '0;
        alu_b     = '0;
        alu_shamt = '0;
        alu_alufn = ALUFN_ADD;
        if (gnt_live) begin
            if (gnt_id == PORT_EX) begin
                alu_a     = req0_a;
                alu_b     = req0_b;
                alu_shamt = req0_shamt;
                alu_alufn = req0_alufn;
            end else begin
                alu_a     = req1_a;
                alu_b     = req1_b;
                alu_shamt = req1_shamt;
                alu_alufn = req1_alufn;
            end
        end
    end

    // Response slot: load on fire (also covers drain+fire), clear on drain only
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_r_d     = rsp_r_q;
        rsp_flags_d = rsp_flags_q;
        if (fire) begin
            rsp_valid_d = 1'b1;
            rsp_id_d    = gnt_id;
            rsp_r_d     = alu_r;
            rsp_flags_d = pack_flags(alu_cf, alu_zf, alu_vf, alu_sf);
        end else if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    // Response register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_r_q     <= '0;
            rsp_flags_q <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_r_q     <= rsp_r_d;
            rsp_flags_q <= rsp_flags_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_r     = rsp_r_q;
    assign rsp_flags = rsp_flags_q;

endmodule
